// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported, fixed-latency memory between the
//            instruction-fetch requester and the load/store requester.
//            One transaction is in flight at a time. Simultaneous requests
//            are resolved round-robin against the previous owner.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset              clock; synchronous active-low reset
//   if_req/if_addr          fetch request, held until if_gnt
//   if_gnt                  fetch accepted (combinational, IDLE only)
//   if_rvalid/if_rdata      fetch response, 1-cycle pulse
//   d_req/d_we/d_addr/
//   d_wdata                 load/store request, held until d_gnt
//   d_gnt                   data accepted (combinational, IDLE only)
//   d_rvalid/d_rdata        load data or store completion (rdata=0)
//   mem_req/mem_we/
//   mem_addr/mem_wdata      memory strobe and captured command
//   mem_rdata               memory read data, valid MEM_LAT cycles after
//                           the mem_req cycle
//   busy                    high whenever a transaction is in flight
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2    // legal range 1..15
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory macro
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // core stall
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // WAIT lasts MEM_LAT cycles: the counter is loaded with MEM_LAT-1 in ISSUE
  // and the read data is sampled in the WAIT cycle where it reaches zero.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_owner_q, last_owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                any_req;
  logic                pick_data;

  assign any_req   = if_req | d_req;
  // Data wins when it is the only requester, or on a tie when fetch owned
  // the previous transaction.
  assign pick_data = d_req & (~if_req | (last_owner_q == OWN_FETCH));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and grants
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Grants are suppressed while reset is asserted so that no request
        // appears accepted during an edge that will clear the state anyway.
        if (reset && any_req) begin
          if (pick_data) begin
            d_gnt        = 1'b1;
            owner_d      = OWN_DATA;
            last_owner_d = OWN_DATA;
            addr_d       = d_addr;
            we_d         = d_we;
            wdata_d      = d_wdata;
          end else begin
            if_gnt       = 1'b1;
            owner_d      = OWN_FETCH;
            last_owner_d = OWN_FETCH;
            addr_d       = if_addr;
            we_d         = 1'b0;
            wdata_d      = '0;
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          // A store completion carries no data.
          rdata_d = we_q ? '0 : mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign busy      = (state_q != S_IDLE);

  assign if_rvalid = (state_q == S_RESP) && (owner_q == OWN_FETCH);
  assign d_rvalid  = (state_q == S_RESP) && (owner_q == OWN_DATA);
  assign if_rdata  = if_rvalid ? rdata_q : '0;
  assign d_rdata   = d_rvalid  ? rdata_q : '0;

endmodule
`default_nettype wire
